// File: rtl/spi_sram_pkg.sv
//==========================================================================
// Package : spi_sram_pkg
// Brief   : Phase codes shared by the SPI-to-SRAM sequencer and controller.
// Rev     : 1.0  initial release
//==========================================================================
`default_nettype none

package spi_sram_pkg;

   localparam int PHASE_W = 5;

   typedef logic [PHASE_W-1:0] phase_t;

   localparam phase_t IDLE       = 5'd0;
   localparam phase_t ADDR1      = 5'd1;
   localparam phase_t ADDR2      = 5'd2;
   localparam phase_t ADDR3      = 5'd3;
   localparam phase_t ADDR4      = 5'd4;
   localparam phase_t ADDR5      = 5'd5;
   localparam phase_t ADDR6      = 5'd6;
   localparam phase_t ADDR7      = 5'd7;
   localparam phase_t ADDR_DONE  = 5'd8;
   localparam phase_t CMD_LOAD   = 5'd9;
   localparam phase_t RX_START   = 5'd10;
   localparam phase_t TX_LOAD    = 5'd11;
   localparam phase_t DATA0      = 5'd12;
   localparam phase_t DATA1      = 5'd13;
   localparam phase_t DATA2      = 5'd14;
   localparam phase_t DATA3      = 5'd15;
   localparam phase_t DATA4      = 5'd16;
   localparam phase_t DATA5      = 5'd17;
   localparam phase_t RX_VALID   = 5'd18;
   localparam phase_t TX_LAST    = 5'd19;
   localparam phase_t TX_CLR     = 5'd20;
   localparam phase_t LAST_PHASE = TX_CLR;

   // Phases that advance on their own after one clk, regardless of sclk.
   function automatic logic is_auto_phase(input phase_t p);
      return (p == ADDR_DONE) || (p == CMD_LOAD) || (p == RX_VALID);
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
//==========================================================================
// Module : spi_sync_edge
// Brief  : Multi-stage synchroniser with a registered rise/fall detector.
// Rev    : 1.0  initial release
//==========================================================================
`default_nettype none

module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_din,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= {SYNC_STAGES{RESET_VAL}};
         r_prev <= RESET_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   // Edges are decoded purely from flops, so no input reaches the outputs combinationally.
   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_prev;
   assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_sram_sequencer.sv
//==========================================================================
// Module : spi_sram_sequencer
// Brief  : Steps the 21-phase SPI/SRAM frame code and issues the bit strobe.
// Rev    : 1.0  initial release
//==========================================================================
`default_nettype none

module spi_sram_sequencer
   import spi_sram_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter logic CPOL        = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sclk,
   input  logic               cs_n,
   output logic [PHASE_W-1:0] phase,
   output logic               cout,
   output logic               busy,
   output logic               abort
);

   logic   w_sclk_level, w_sclk_rise, w_sclk_fall;
   logic   w_cs_level, w_cs_rise, w_cs_fall;
   logic   w_sclk_edge, w_active, w_unused;
   phase_t w_next;

   phase_t r_phase;
   logic   r_cout, r_busy, r_abort, r_cs_fall;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_din   (sclk),
      .o_level (w_sclk_level),
      .o_rise  (w_sclk_rise),
      .o_fall  (w_sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_din   (cs_n),
      .o_level (w_cs_level),
      .o_rise  (w_cs_rise),
      .o_fall  (w_cs_fall)
   );

   assign w_unused    = &{1'b0, w_sclk_level, w_cs_rise};
   assign w_sclk_edge = CPOL ? w_sclk_fall : w_sclk_rise;
   assign w_active    = (r_phase != IDLE);

   // Deselect outranks every advance; out-of-range codes fall back to IDLE.
   always_comb begin
      w_next = r_phase;
      if (r_phase > LAST_PHASE) begin
         w_next = IDLE;
      end else if (w_active && w_cs_level) begin
         w_next = IDLE;
      end else if (r_phase == IDLE) begin
         if (r_cs_fall) w_next = ADDR1;
      end else if (r_phase == TX_CLR) begin
         w_next = IDLE;
      end else if (is_auto_phase(r_phase)) begin
         w_next = r_phase + 5'd1;
      end else if (r_cout) begin
         w_next = r_phase + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase   <= IDLE;
         r_cout    <= 1'b0;
         r_busy    <= 1'b0;
         r_abort   <= 1'b0;
         r_cs_fall <= 1'b0;
      end else begin
         r_phase   <= w_next;
         r_cout    <= w_sclk_edge & w_active;
         r_busy    <= (w_next != IDLE);
         r_abort   <= w_cs_level & w_active & (r_phase != TX_CLR);
         r_cs_fall <= w_cs_fall;
      end
   end

   assign phase = r_phase;
   assign cout  = r_cout;
   assign busy  = r_busy;
   assign abort = r_abort;

endmodule

`default_nettype wire

// File: tb/tb_spi_sram_sequencer.sv
//==========================================================================
// Module : tb_spi_sram_sequencer
// Brief  : Directed bench for spi_sram_sequencer, CPOL=0 and CPOL=1 copies.
// Rev    : 1.0  initial release
//==========================================================================
`default_nettype none

module tb_spi_sram_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, sclk, cs_n, sclk_inv;
   logic [4:0] phase0, phase1;
   logic       cout0, busy0, abort0, cout1, busy1, abort1;

   int total = 0;
   int bad   = 0;
   int ncout0, ncout1, nabort0, nabort1;
   int q0[$];
   int q1[$];
   logic [4:0] last0 = 5'd0;
   logic [4:0] last1 = 5'd0;

   assign sclk_inv = ~sclk;

   spi_sram_sequencer #(.SYNC_STAGES(2), .CPOL(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n),
      .phase(phase0), .cout(cout0), .busy(busy0), .abort(abort0)
   );

   spi_sram_sequencer #(.SYNC_STAGES(2), .CPOL(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk_inv), .cs_n(cs_n),
      .phase(phase1), .cout(cout1), .busy(busy1), .abort(abort1)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cout0)  ncout0++;
      if (cout1)  ncout1++;
      if (abort0) nabort0++;
      if (abort1) nabort1++;
      if (phase0 !== last0) begin q0.push_back(int'(phase0)); last0 = phase0; end
      if (phase1 !== last1) begin q1.push_back(int'(phase1)); last1 = phase1; end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic clear_mon();
      ncout0 = 0; ncout1 = 0; nabort0 = 0; nabort1 = 0;
      q0.delete(); q1.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   // One 8-clk sclk period, entered and left on a negedge.
   task automatic sclk_cycle();
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic start_frame();
      cs_n = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic do_frame(input string tag);
      logic [4:0] ph_obs[4];
      logic       co_obs[3];
      logic [4:0] ph_at_cout;
      clear_mon();
      @(negedge clk);
      cs_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1; ph_obs[k] = phase0;
      end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (ph_obs[k] !== ((k == 3) ? 5'd1 : 5'd0)) begin
            bad++;
            $display("FAIL %s start_lat[%0d]: phase got %0d want %0d", tag, k, ph_obs[k], (k == 3) ? 1 : 0);
         end
      end
      @(negedge clk);
      sclk = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1; co_obs[k] = cout0;
         if (k == 2) ph_at_cout = phase0;
      end
      for (int k = 0; k < 3; k++) begin
         total++;
         if (co_obs[k] !== ((k == 2) ? 1'b1 : 1'b0)) begin
            bad++;
            $display("FAIL %s cout_lat[%0d]: cout got %0b want %0b", tag, k, co_obs[k], (k == 2));
         end
      end
      total++;
      if (ph_at_cout !== 5'd1) begin
         bad++;
         $display("FAIL %s pre_advance: phase got %0d want 1", tag, ph_at_cout);
      end
      @(negedge clk);
      @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if (phase0 !== 5'd2) begin
         bad++;
         $display("FAIL %s after_edge1: phase got %0d want 2", tag, phase0);
      end
      repeat (15) sclk_cycle();
      repeat (4) @(negedge clk);
      total++;
      if (phase0 !== 5'd0 || busy0 !== 1'b0) begin
         bad++;
         $display("FAIL %s frame_end: phase/busy got %0d/%0b want 0/0", tag, phase0, busy0);
      end
      cs_n = 1'b1;
      repeat (6) @(negedge clk);
      total++;
      if (ncout0 !== 16) begin bad++; $display("FAIL %s cout_count0: got %0d want 16", tag, ncout0); end
      total++;
      if (ncout1 !== 16) begin bad++; $display("FAIL %s cout_count1: got %0d want 16", tag, ncout1); end
      total++;
      if (nabort0 !== 0 || nabort1 !== 0) begin
         bad++;
         $display("FAIL %s abort_count: got %0d/%0d want 0/0", tag, nabort0, nabort1);
      end
      total++;
      if (q0.size() !== 21 || q1.size() !== 21) begin
         bad++;
         $display("FAIL %s seq_len: got %0d/%0d want 21/21", tag, q0.size(), q1.size());
      end else begin
         for (int i = 0; i < 21; i++) begin
            total++;
            if (q0[i] !== (i + 1) % 21) begin
               bad++;
               $display("FAIL %s seq0[%0d]: phase got %0d want %0d", tag, i, q0[i], (i + 1) % 21);
            end
            total++;
            if (q1[i] !== (i + 1) % 21) begin
               bad++;
               $display("FAIL %s seq1_cpol1[%0d]: phase got %0d want %0d", tag, i, q1[i], (i + 1) % 21);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({phase0, cout0, busy0, abort0} !== 8'd0 || {phase1, cout1, busy1, abort1} !== 8'd0) begin
         bad++;
         $display("FAIL reset_state: got %0h/%0h want 0/0", {phase0, cout0, busy0, abort0}, {phase1, cout1, busy1, abort1});
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      total++;
      if ({phase0, cout0, busy0, abort0} !== 8'd0) begin
         bad++;
         $display("FAIL post_reset_idle: got %0h want 0", {phase0, cout0, busy0, abort0});
      end
   endtask

   task automatic test_full_frame();
      do_reset();
      do_frame("full_frame");
   endtask

   task automatic test_abort();
      logic found;
      do_reset();
      clear_mon();
      start_frame();
      repeat (10) sclk_cycle();
      total++;
      if (phase0 !== 5'd13) begin bad++; $display("FAIL abort_pre: phase got %0d want 13", phase0); end
      cs_n = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (phase0 === 5'd0) begin found = 1'b1; break; end
      end
      total++;
      if (found !== 1'b1) begin bad++; $display("FAIL abort_latency: phase got %0d want 0", phase0); end
      repeat (4) @(negedge clk);
      total++;
      if (nabort0 !== 1 || nabort1 !== 1) begin
         bad++;
         $display("FAIL abort_pulses: got %0d/%0d want 1/1", nabort0, nabort1);
      end
      ncout0 = 0;
      repeat (3) sclk_cycle();
      total++;
      if (ncout0 !== 0 || phase0 !== 5'd0 || busy0 !== 1'b0) begin
         bad++;
         $display("FAIL abort_quiet: cout/phase/busy got %0d/%0d/%0b want 0/0/0", ncout0, phase0, busy0);
      end
   endtask

   task automatic test_simultaneous();
      logic seen6;
      do_reset();
      clear_mon();
      start_frame();
      repeat (4) sclk_cycle();
      total++;
      if (phase0 !== 5'd5) begin bad++; $display("FAIL simul_pre: phase got %0d want 5", phase0); end
      sclk = 1'b1;
      @(negedge clk);
      cs_n = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if (cout0 !== 1'b1 || phase0 !== 5'd5) begin
         bad++;
         $display("FAIL simul_cout: cout/phase got %0b/%0d want 1/5", cout0, phase0);
      end
      @(posedge clk); #1;
      total++;
      if (phase0 !== 5'd0 || abort0 !== 1'b1) begin
         bad++;
         $display("FAIL simul_abort: phase/abort got %0d/%0b want 0/1", phase0, abort0);
      end
      @(negedge clk);
      sclk = 1'b0;
      repeat (6) @(negedge clk);
      seen6 = 1'b0;
      foreach (q0[i]) if (q0[i] == 6) seen6 = 1'b1;
      total++;
      if (seen6 !== 1'b0 || nabort0 !== 1) begin
         bad++;
         $display("FAIL simul_history: seen6/aborts got %0b/%0d want 0/1", seen6, nabort0);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      clear_mon();
      start_frame();
      repeat (12) sclk_cycle();
      total++;
      if (phase0 !== 5'd15) begin bad++; $display("FAIL areset_pre: phase got %0d want 15", phase0); end
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      total++;
      if (phase0 !== 5'd0 || busy0 !== 1'b0 || abort0 !== 1'b0 || cout0 !== 1'b0) begin
         bad++;
         $display("FAIL areset_immediate: phase/busy/abort got %0d/%0b/%0b want 0/0/0", phase0, busy0, abort0);
      end
      cs_n = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      total++;
      if (nabort0 !== 0 || phase0 !== 5'd0) begin
         bad++;
         $display("FAIL areset_no_abort: aborts/phase got %0d/%0d want 0/0", nabort0, phase0);
      end
      do_frame("after_areset");
   endtask

   task automatic test_extra_edges();
      do_reset();
      clear_mon();
      start_frame();
      repeat (20) sclk_cycle();
      repeat (2) @(negedge clk);
      total++;
      if (ncout0 !== 16 || ncout1 !== 16) begin
         bad++;
         $display("FAIL extra_cout: got %0d/%0d want 16/16", ncout0, ncout1);
      end
      total++;
      if (phase0 !== 5'd0 || busy0 !== 1'b0) begin
         bad++;
         $display("FAIL extra_idle: phase/busy got %0d/%0b want 0/0", phase0, busy0);
      end
      cs_n = 1'b1;
      repeat (6) @(negedge clk);
      cs_n = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if (phase0 !== 5'd1) begin bad++; $display("FAIL extra_restart: phase got %0d want 1", phase0); end
      sclk_cycle();
      total++;
      if (phase0 !== 5'd2 || ncout0 !== 17 || nabort0 !== 0) begin
         bad++;
         $display("FAIL extra_resume: phase/cout/abort got %0d/%0d/%0d want 2/17/0", phase0, ncout0, nabort0);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_abort();
      test_simultaneous();
      test_async_reset();
      test_extra_edges();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
